boreal_vns_scheduler: RTL and testbench

// Shares the single tVNS burst stimulator between N reward requesters (active-inference match, calibration, clinician manual).

---
 rtl/boreal_vns_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_boreal_vns_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_vns_scheduler.sv
// Round-robin scheduler sharing one tVNS burst stimulator between N_REQ requesters,
// with interlock gating, intensity clamp, start-timeout fault, refractory gap and request timeouts.
module boreal_vns_scheduler #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned REFRACT_CYCLES = 100_000_000,
    parameter int unsigned START_TIMEOUT  = 16,
    parameter int unsigned REQ_TIMEOUT    = 50_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_req_intensity,
    input  logic [7:0]           i_max_intensity,
    input  logic                 i_stim_busy,
    input  logic                 i_safety_active,
    input  logic                 i_ad_guard_active,
    input  logic                 i_fault_clr,
    output logic [N_REQ-1:0]     o_req_ack,
    output logic [N_REQ-1:0]     o_req_reject,
    output logic                 o_trigger_out,
    output logic [7:0]           o_intensity_out,
    output logic                 o_sched_busy,
    output logic                 o_start_fault,
    output logic [15:0]          o_burst_count
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned IDX_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitStart,
        StBusy,
        StRefract
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [31:0]         r_cnt;
    logic [31:0]         w_cnt_next;
    logic [PTR_W-1:0]    r_rr;
    logic [31:0]         r_wait [N_REQ];
    logic [N_REQ-1:0]    r_ack;
    logic [N_REQ-1:0]    r_reject;
    logic                r_trigger;
    logic [7:0]          r_intensity;
    logic                r_busy;
    logic                r_fault;
    logic [15:0]         r_burst_count;

    logic                w_inhibit;
    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    logic [IDX_W-1:0]    w_idx;
    logic                w_grant;
    logic                w_fault_set;
    logic                w_burst_inc;
    logic [N_REQ-1:0]    w_ack_vec;
    logic [7:0]          w_sel_int;
    logic [7:0]          w_clamped;
    logic [PTR_W-1:0]    w_rr_next;

    assign w_inhibit = i_safety_active | i_ad_guard_active;

    // First pending request at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr} + IDX_W'(k);
            if (w_idx >= IDX_W'(N_REQ)) begin
                w_idx = w_idx - IDX_W'(N_REQ);
            end
            if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_sel_int = i_req_intensity[{w_winner, 3'b000} +: 8];
    assign w_clamped = (w_sel_int > i_max_intensity) ? i_max_intensity : w_sel_int;
    assign w_ack_vec = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;
    assign w_rr_next = (w_winner == PTR_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant      = 1'b0;
        w_fault_set  = 1'b0;
        w_burst_inc  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found && !w_inhibit) begin
                    w_grant      = 1'b1;
                    w_state_next = StWaitStart;
                    w_cnt_next   = '0;
                end
            end
            StWaitStart: begin
                if (i_stim_busy) begin
                    w_state_next = StBusy;
                    w_burst_inc  = 1'b1;
                end else if (r_cnt == START_TIMEOUT - 1) begin
                    w_fault_set  = 1'b1;
                    w_state_next = StRefract;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            StBusy: begin
                // Inhibits are ignored here: the stimulator owns the mid-burst cut-off.
                if (!i_stim_busy) begin
                    w_state_next = StRefract;
                    w_cnt_next   = '0;
                end
            end
            StRefract: begin
                if (r_cnt == REFRACT_CYCLES - 1) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_rr          <= '0;
            r_ack         <= '0;
            r_trigger     <= 1'b0;
            r_intensity   <= '0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_burst_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_ack     <= w_ack_vec;
            r_trigger <= w_grant;
            r_busy    <= (w_state_next != StIdle);
            if (w_grant) begin
                r_rr        <= w_rr_next;
                r_intensity <= w_clamped;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end else if (i_fault_clr) begin
                r_fault <= 1'b0;
            end
            if (w_burst_inc && (r_burst_count != 16'hFFFF)) begin
                r_burst_count <= r_burst_count + 16'd1;
            end
        end
    end

    // Per-requester wait counters; a same-cycle ack suppresses the reject.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reject <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_reject[i] <= i_req[i] && !w_ack_vec[i] && (r_wait[i] == REQ_TIMEOUT - 1);
                if (!i_req[i] || w_ack_vec[i] || (r_wait[i] == REQ_TIMEOUT - 1)) begin
                    r_wait[i] <= '0;
                end else begin
                    r_wait[i] <= r_wait[i] + 32'd1;
                end
            end
        end
    end

    assign o_req_ack       = r_ack;
    assign o_req_reject    = r_reject;
    assign o_trigger_out   = r_trigger;
    assign o_intensity_out = r_intensity;
    assign o_sched_busy    = r_busy;
    assign o_start_fault   = r_fault;
    assign o_burst_count   = r_burst_count;

endmodule

// File: tb/tb_boreal_vns_scheduler.sv
// Directed-vector bench for boreal_vns_scheduler; u_dut runs the main scenarios,
// u_rr (long request timeout) runs the held-request round-robin scenario.
module tb_boreal_vns_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_int;
    logic [7:0]  max_int;
    logic        stim_busy;
    logic        safety;
    logic        guard;
    logic        fclr;

    logic [2:0]  d_ack, d_rej, r_ack, r_rej;
    logic        d_trig, d_busy, d_fault, r_trig, r_busy, r_fault;
    logic [7:0]  d_int, r_int;
    logic [15:0] d_burst, r_burst;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    boreal_vns_scheduler #(
        .N_REQ(3), .REFRACT_CYCLES(20), .START_TIMEOUT(16), .REQ_TIMEOUT(50)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_intensity(req_int),
        .i_max_intensity(max_int), .i_stim_busy(stim_busy), .i_safety_active(safety),
        .i_ad_guard_active(guard), .i_fault_clr(fclr),
        .o_req_ack(d_ack), .o_req_reject(d_rej), .o_trigger_out(d_trig),
        .o_intensity_out(d_int), .o_sched_busy(d_busy), .o_start_fault(d_fault),
        .o_burst_count(d_burst)
    );

    boreal_vns_scheduler #(
        .N_REQ(3), .REFRACT_CYCLES(20), .START_TIMEOUT(16), .REQ_TIMEOUT(10000)
    ) u_rr (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_intensity(req_int),
        .i_max_intensity(max_int), .i_stim_busy(stim_busy), .i_safety_active(safety),
        .i_ad_guard_active(guard), .i_fault_clr(fclr),
        .o_req_ack(r_ack), .o_req_reject(r_rej), .o_trigger_out(r_trig),
        .o_intensity_out(r_int), .o_sched_busy(r_busy), .o_start_fault(r_fault),
        .o_burst_count(r_burst)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (d_busy && n < 300) begin
            tick();
            n++;
        end
        check_eq("idle_wait_timeout", {31'b0, d_busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_ack [4];
        logic [7:0] exp_int [4];
        int n;
        int t_fall;
        logic bad;

        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_int = '{8'd10, 8'd20, 8'd30, 8'd10};

        rst = 1'b1; req = '0; req_int = '0; max_int = 8'd255;
        stim_busy = 1'b0; safety = 1'b0; guard = 1'b0; fclr = 1'b0;
        repeat (2) tick();
        check_eq("rst_trig",  {31'b0, d_trig}, 32'd0);
        check_eq("rst_ack",   {29'b0, d_ack}, 32'd0);
        check_eq("rst_rej",   {29'b0, d_rej}, 32'd0);
        check_eq("rst_int",   {24'b0, d_int}, 32'd0);
        check_eq("rst_busy",  {31'b0, d_busy}, 32'd0);
        check_eq("rst_fault", {31'b0, d_fault}, 32'd0);
        check_eq("rst_burst", {16'b0, d_burst}, 32'd0);
        rst = 1'b0;
        tick();

        // T2: held req=111, 10-cycle bursts, grant exactly 22 cycles after busy falls
        // (1 to sample the fall, 20 refractory, 1 to grant).
        req = 3'b111;
        req_int = {8'd30, 8'd20, 8'd10};
        t_fall = 0;
        for (int g = 0; g < 4; g++) begin
            for (n = 0; n < 200; n++) begin
                tick();
                if (r_trig) break;
            end
            check_eq("rr_ack", {29'b0, r_ack}, {29'b0, exp_ack[g]});
            check_eq("rr_int", {24'b0, r_int}, {24'b0, exp_int[g]});
            if (g > 0) check_eq("rr_gap", cyc - t_fall, 32'd22);
            if (g < 3) begin
                tick();
                stim_busy = 1'b1;
                repeat (10) tick();
                stim_busy = 1'b0;
                t_fall = cyc;
            end
        end
        req = '0;
        check_eq("rr_burst", {16'b0, r_burst}, 32'd3);
        check_eq("rr_no_rej", {29'b0, r_rej}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // T1: single request, 1-clock latency, refractory length.
        req = 3'b001;
        req_int = {8'd200, 8'd0, 8'd40};
        tick();
        check_eq("t1_trig", {31'b0, d_trig}, 32'd1);
        check_eq("t1_ack",  {29'b0, d_ack}, 32'd1);
        check_eq("t1_int",  {24'b0, d_int}, 32'd40);
        check_eq("t1_busy", {31'b0, d_busy}, 32'd1);
        req = '0;
        tick();
        check_eq("t1_trig_pulse", {31'b0, d_trig}, 32'd0);
        check_eq("t1_ack_pulse",  {29'b0, d_ack}, 32'd0);
        stim_busy = 1'b1;
        tick();
        check_eq("t1_burst", {16'b0, d_burst}, 32'd1);
        stim_busy = 1'b0;
        wait_idle(n);
        check_eq("t1_refract_len", n, 32'd21);

        // T3 + T5: pointer now 1, req=100 wins with clamp; no stim start -> fault.
        req = 3'b100;
        max_int = 8'd120;
        tick();
        check_eq("t3_trig", {31'b0, d_trig}, 32'd1);
        check_eq("t3_ack",  {29'b0, d_ack}, 32'd4);
        check_eq("t3_clamp", {24'b0, d_int}, 32'd120);
        req = '0;
        repeat (14) tick();
        fclr = 1'b1;
        tick();
        check_eq("t5_fault_early", {31'b0, d_fault}, 32'd0);
        tick();
        check_eq("t5_fault_set_wins", {31'b0, d_fault}, 32'd1);
        check_eq("t5_refract_busy", {31'b0, d_busy}, 32'd1);
        fclr = 1'b0;
        tick();
        check_eq("t5_fault_sticky", {31'b0, d_fault}, 32'd1);
        fclr = 1'b1;
        tick();
        check_eq("t5_fault_clr", {31'b0, d_fault}, 32'd0);
        fclr = 1'b0;
        wait_idle(n);
        req = 3'b010;
        tick();
        check_eq("t5_regrant_trig", {31'b0, d_trig}, 32'd1);
        check_eq("t5_regrant_ack",  {29'b0, d_ack}, 32'd2);
        check_eq("t5_zero_int",     {24'b0, d_int}, 32'd0);
        req = '0;
        stim_busy = 1'b1;
        tick();
        check_eq("t5_burst", {16'b0, d_burst}, 32'd2);
        stim_busy = 1'b0;
        wait_idle(n);

        // T4: guard holds req=010 pending until the 50-cycle reject.
        guard = 1'b1;
        req = 3'b010;
        repeat (49) tick();
        check_eq("t4_no_rej_yet", {29'b0, d_rej}, 32'd0);
        check_eq("t4_no_grant",   {31'b0, d_busy}, 32'd0);
        tick();
        check_eq("t4_rej",      {29'b0, d_rej}, 32'd2);
        check_eq("t4_rej_noack", {29'b0, d_ack}, 32'd0);
        req = '0;
        tick();
        check_eq("t4_rej_pulse", {29'b0, d_rej}, 32'd0);
        req = 3'b010;
        safety = 1'b1;
        repeat (30) tick();
        guard = 1'b0;
        safety = 1'b0;
        tick();
        check_eq("t4_late_ack",  {29'b0, d_ack}, 32'd2);
        check_eq("t4_late_trig", {31'b0, d_trig}, 32'd1);
        req = '0;
        stim_busy = 1'b1;
        tick();
        stim_busy = 1'b0;
        bad = 1'b0;
        repeat (25) begin
            tick();
            bad = bad | (|d_rej);
        end
        check_eq("t4_late_no_rej", {31'b0, bad}, 32'd0);
        wait_idle(n);

        // T6: pointer is 2 -> req=001 grants, pointer becomes 1; reset mid-BUSY.
        req = 3'b001;
        tick();
        check_eq("t6_pre_ack", {29'b0, d_ack}, 32'd1);
        req = 3'b011;
        stim_busy = 1'b1;
        repeat (2) tick();
        check_eq("t6_in_busy", {31'b0, d_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_trig",  {31'b0, d_trig}, 32'd0);
        check_eq("t6_rst_busy",  {31'b0, d_busy}, 32'd0);
        check_eq("t6_rst_int",   {24'b0, d_int}, 32'd0);
        check_eq("t6_rst_burst", {16'b0, d_burst}, 32'd0);
        check_eq("t6_rst_ack",   {29'b0, d_ack}, 32'd0);
        stim_busy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_eq("t6_post_ack",  {29'b0, d_ack}, 32'd1);
        check_eq("t6_post_trig", {31'b0, d_trig}, 32'd1);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
